// File: rtl/case_stream_converter.sv
// Streaming ASCII case converter: LANES bytes per beat, selectable case mode,
// 2-entry skid buffer for full throughput, saturating count of changed bytes.
module case_stream_converter #(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*LANES-1:0]   in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  output logic                 out_last,
  input  logic                 count_clr,
  output logic [CNT_W-1:0]     conv_count
);

  localparam int W  = 8 * LANES;
  localparam int NW = $clog2(LANES + 1);
  localparam int SW = CNT_W + NW + 1;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic [W-1:0]     skid_data_q, skid_data_d;
  logic             skid_last_q, skid_last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [W-1:0]     conv_data;
  logic [NW-1:0]    conv_n;
  logic             in_xfer, out_xfer;

  function automatic logic [7:0] conv_byte(input logic [7:0] b, input logic [1:0] m);
    logic is_up, is_lo;
    logic [7:0] r;
    is_up = (b >= 8'h41) && (b <= 8'h5A);
    is_lo = (b >= 8'h61) && (b <= 8'h7A);
    r = b;
    case (m)
      2'b01:   if (is_lo) r = b & 8'hDF;
      2'b10:   if (is_up) r = b | 8'h20;
      2'b11:   if (is_up || is_lo) r = b ^ 8'h20;
      default: r = b;
    endcase
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [NW-1:0] n);
    logic [SW-1:0] sum;
    logic [SW-1:0] max_v;
    sum   = SW'(c) + SW'(n);
    max_v = SW'({CNT_W{1'b1}});
    if (sum > max_v) return {CNT_W{1'b1}};
    return sum[CNT_W-1:0];
  endfunction

  // Conversion and changed-lane count, ahead of the buffer registers
  always_comb begin
    conv_data = '0;
    conv_n    = '0;
    for (int i = 0; i < LANES; i++) begin
      conv_data[8*i +: 8] = conv_byte(in_data[8*i +: 8], mode);
      if (conv_data[8*i +: 8] != in_data[8*i +: 8]) conv_n = conv_n + NW'(1);
    end
  end

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d    = ONE;
          out_data_d = conv_data;
          out_last_d = in_last;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          out_data_d = conv_data;
          out_last_d = in_last;
        end else if (in_xfer) begin
          state_d     = TWO;
          skid_data_d = conv_data;
          skid_last_d = in_last;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          state_d    = ONE;
          out_data_d = skid_data_q;
          out_last_d = skid_last_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d  = (state_d != TWO);
    out_valid_d = (state_d != EMPTY);
  end

  // Clear takes priority so a same-cycle beat's changes are dropped
  always_comb begin
    cnt_d = cnt_q;
    if (count_clr)    cnt_d = '0;
    else if (in_xfer) cnt_d = sat_add(cnt_q, conv_n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      skid_data_q <= '0;
      skid_last_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      skid_data_q <= skid_data_d;
      skid_last_q <= skid_last_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign conv_count = cnt_q;

endmodule

// File: tb/tb_case_stream_converter.sv
// Scoreboard bench for case_stream_converter: directed beats, backpressure,
// counter saturation on a narrow-counter instance, and mid-stream async reset.
module tb_case_stream_converter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic        in_valid, in_ready, in_last;
  logic [31:0] in_data;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic        count_clr;
  logic [15:0] conv_count;

  logic [1:0]  mode4;
  logic        in_valid4, in_ready4, out_valid4, out_last4, count_clr4;
  logic        out_ready4;
  logic [31:0] in_data4, out_data4;
  logic [3:0]  conv_count4;

  always #5 clk = ~clk;

  case_stream_converter #(.LANES(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .count_clr(count_clr), .conv_count(conv_count));

  case_stream_converter #(.LANES(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .mode(mode4),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_last(1'b0),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4), .out_last(out_last4),
    .count_clr(count_clr4), .conv_count(conv_count4));

  typedef struct { logic [31:0] data; logic last; } beat_t;
  beat_t q[$];

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  bit mon_en = 0;
  bit bp_en = 0;
  int ph = 0;
  logic [31:0] drv_exp;
  logic        drv_last;
  int          drv_n;
  bit          have_hold = 0;
  logic [31:0] hold_data;
  logic        hold_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard: sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      exp_cnt   = 0;
      have_hold = 0;
    end else if (mon_en) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
      chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
      chk("conv_count", {16'b0, conv_count}, exp_cnt[31:0]);
      if (out_valid && have_hold) begin
        chk("hold_data", out_data, hold_data);
        chk("hold_last", {31'b0, out_last}, {31'b0, hold_last});
      end
      if (out_valid && out_ready) begin
        have_hold = 0;
        if (q.size() == 0) begin
          chk("pop_empty", 32'd1, 32'd0);
        end else begin
          beat_t b;
          b = q.pop_front();
          chk("out_data", out_data, b.data);
          chk("out_last", {31'b0, out_last}, {31'b0, b.last});
        end
      end else if (out_valid) begin
        have_hold = 1;
        hold_data = out_data;
        hold_last = out_last;
      end else begin
        have_hold = 0;
      end
      if (count_clr) exp_cnt = 0;
      else if (in_valid && in_ready) exp_cnt = exp_cnt + drv_n;
      if (in_valid && in_ready) begin
        beat_t nb;
        nb.data = drv_exp;
        nb.last = drv_last;
        q.push_back(nb);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (bp_en) begin
      out_ready = (ph == 0 || ph == 3);
      ph = (ph + 1) % 4;
    end
  end

  task automatic send(input logic [1:0] m, input logic [31:0] d, input logic l,
                      input logic [31:0] e, input int n);
    bit ok;
    int k;
    ok = 0;
    k  = 0;
    mode = m; in_data = d; in_last = l;
    drv_exp = e; drv_last = l; drv_n = n;
    in_valid = 1'b1;
    while (!ok && k < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      k++;
    end
    if (!ok) chk("send_timeout", 32'd1, 32'd0);
    in_valid = 1'b0;
    mode = 2'b11;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] b;
    rst_n = 1'b0; mode = 2'b00; in_valid = 0; in_data = '0; in_last = 0;
    out_ready = 1'b1; count_clr = 0; drv_exp = '0; drv_last = 0; drv_n = 0;
    mode4 = 2'b01; in_valid4 = 0; in_data4 = '0; out_ready4 = 1'b1; count_clr4 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_last", {31'b0, out_last}, 32'd0);
    chk("rst_conv_count", {16'b0, conv_count}, 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", {31'b0, in_ready}, 32'd1);
    mon_en = 1;
    @(posedge clk); #1;

    send(2'b01, 32'h7A416128, 1'b0, 32'h5A414128, 2);
    send(2'b11, 32'h7B6D47EB, 1'b0, 32'h7B4D67EB, 2);
    send(2'b10, 32'h7F405A5B, 1'b0, 32'h7F407A5B, 1);
    send(2'b00, 32'h61415A7A, 1'b1, 32'h61415A7A, 0);
    drain();
    @(negedge clk);
    chk("cnt_after_directed", {16'b0, conv_count}, 32'd5);
    @(posedge clk); #1;

    ph = 0; bp_en = 1;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        b = 8'h61 + 8'(i);
        send(2'b01, {b, 8'h31, 8'h41, 8'h7A}, i == 7, {b & 8'hDF, 8'h31, 8'h41, 8'h5A}, 2);
      end else begin
        b = 8'h41 + 8'(i);
        send(2'b10, {b, 8'h31, 8'h61, 8'h7A}, i == 7, {b | 8'h20, 8'h31, 8'h61, 8'h7A}, 1);
      end
    end
    drain();
    bp_en = 0; out_ready = 1'b1;
    @(negedge clk);
    chk("cnt_after_bp", {16'b0, conv_count}, 32'd17);

    @(posedge clk); #1;
    in_valid4 = 1'b1; in_data4 = 32'h61616161;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("cnt4_12", {28'b0, conv_count4}, 32'd12);
    chk("out4_data", out_data4, 32'h41414141);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("cnt4_sat", {28'b0, conv_count4}, 32'd15);
    chk("in4_ready", {31'b0, in_ready4}, 32'd1);
    count_clr4 = 1'b1;
    @(posedge clk); #1;
    count_clr4 = 1'b0; in_valid4 = 1'b0;
    @(negedge clk);
    chk("cnt4_clr", {28'b0, conv_count4}, 32'd0);

    @(posedge clk); #1;
    out_ready = 1'b0;
    send(2'b01, 32'h61626364, 1'b0, 32'h41424344, 4);
    send(2'b01, 32'h65666768, 1'b1, 32'h45464748, 4);
    @(negedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_conv_count", {16'b0, conv_count}, 32'd0);
    chk("arst_out_data", out_data, 32'd0);
    @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    send(2'b11, 32'h41627A30, 1'b1, 32'h61425A30, 3);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
